div_scheduler: RTL and testbench
================================

Name: div_scheduler

Overview:
Shares one iterative signed divider between NUM_REQ independent requesters.
- Round-robin arbitration; accepts one operand pair at a time.
- Launches the divider and holds its operands stable until the result returns.
- Returns quotient/remainder/overflow on one shared response channel tagged with the requester id.
- Sits between the pipeline stages that need division (slope/normalisation math) and the single divider instance.

Parameters:
- NUM_REQ, 4: number of requesters; 2 to 8.
- DATA_WIDTH, DATA_SIZE (globals): operand and result width; signed two's complement.
- TIMEOUT, 1024: maximum cycles spent waiting for the divider before a forced timeout response.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_dividend  in  NUM_REQ*DATA_WIDTH  packed dividends; requester i at bits [i*W +: W].
- req_divisor  in  NUM_REQ*DATA_WIDTH  packed divisors, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response.
- rsp_quotient  out  DATA_WIDTH  quotient.
- rsp_remainder  out  DATA_WIDTH  remainder.
- rsp_overflow  out  1  divide-by-zero flag from the divider.
- rsp_timeout  out  1  divider did not answer within TIMEOUT cycles.
- div_valid_in  out  1  divider start strobe.
- div_dividend  out  DATA_WIDTH  divider operand.
- div_divisor  out  DATA_WIDTH  divider operand.
- div_quotient  in  DATA_WIDTH  divider result.
- div_remainder  in  DATA_WIDTH  divider result.
- div_valid_out  in  1  divider result strobe, single cycle.
- div_overflow  in  1  divider overflow.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0; wait counter=0.
  - req_ready=0, div_valid_in=0, rsp_valid=0, rsp_timeout=0, rsp_overflow=0.
  - All data outputs 0; rsp_id=0.
  - Reset mid-operation abandons the in-flight job silently. The divider shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid: pick the first set bit scanning from rr_ptr upward, wrapping mod NUM_REQ. Call it g.
  - Same cycle: req_ready[g]=1 (combinational from req_valid and rr_ptr). Latch operands and id=g. rr_ptr<=g+1 mod NUM_REQ. Next state ISSUE.
  - Otherwise stay in IDLE with req_ready=0.
- ISSUE:
  - div_valid_in=1 for exactly one cycle; wait counter cleared. Next state WAIT.
- WAIT:
  - div_dividend/div_divisor are held at the latched values from ISSUE through the div_valid_out cycle. The divider re-reads its inputs until completion.
  - On div_valid_out: capture quotient, remainder and overflow; rsp_timeout<=0; next state RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without div_valid_out: capture zeros, rsp_timeout<=1, next state RESP.
  - Any div_valid_out outside WAIT is ignored.
- RESP:
  - rsp_valid=1 and all rsp_* fields stable until rsp_ready.
  - rsp_valid && rsp_ready: next state IDLE, rsp_valid deasserts the next cycle.
  - No new request is accepted while in ISSUE, WAIT or RESP. There is a mandatory one-cycle IDLE bubble between jobs.
- Latency: accept at cycle T; div_valid_in at T+1; rsp_valid at cycle D+1 after div_valid_in, where D is the divider latency (div_valid_out at T+1+D).
- Fairness: a requester that holds req_valid waits at most NUM_REQ-1 other jobs.
- Arithmetic: no sign or width manipulation; operands and results pass through unchanged. Divisor 0 is forwarded; overflow is reported via rsp_overflow.
- Requesters may drop req_valid before being granted with no effect. Operands are sampled only on the req_ready cycle.

Decomposition:
- Shared package (globals): state enum sched_state_t {IDLE, ISSUE, WAIT, RESP}; NUM_REQ default constant; TIMEOUT default.
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Parameterised by NUM_REQ.
- Top: FSM, operand/result registers, wait counter.

Test Plan:
- Single request, 0 idle cycles: requester 2 sends 100/7 → req_ready[2] in the same cycle; div_valid_in one cycle later; rsp_id=2, quotient 14, remainder 2, rsp_overflow=0.
- All 4 requesters valid continuously from reset, each with operands (i+1)*10 / 3 → grants in order 0,1,2,3,0; rsp_id follows the same order; no requester starved.
- Divisor zero: requester 1 sends 55/0 → rsp_overflow=1, rsp_id=1, rsp_timeout=0.
- Backpressure: rsp_ready low for 20 cycles in RESP → rsp fields stable; req_ready stays 0 despite other valid requests; response retires on the first rsp_ready cycle.
- Timeout: a divider model that never asserts div_valid_out, TIMEOUT=16 → rsp_valid with rsp_timeout=1, quotient and remainder 0, exactly 16 cycles after div_valid_in.
- Reset mid-WAIT: assert reset for one cycle during WAIT → all outputs at reset values; a later request to requester 3 with -20/6 completes normally (quotient -3, remainder -2); rr_ptr restarts at 0.

Source files
------------

// File: rtl/div_scheduler_pkg.sv
// Shared types and defaults for the divider scheduler.
// Imported by the interface, the arbiter and the top.
package div_scheduler_pkg;

    localparam int DATA_SIZE   = 32;
    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Requester, response and divider-side signals of the scheduler.
// slave is the scheduler view, master the surrounding logic.
interface div_scheduler_if
    import div_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_SIZE
);
    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [DATA_WIDTH-1:0] rsp_quotient;
    logic [DATA_WIDTH-1:0] rsp_remainder;
    logic                  rsp_overflow;
    logic                  rsp_timeout;

    logic                  div_valid_in;
    logic [DATA_WIDTH-1:0] div_dividend;
    logic [DATA_WIDTH-1:0] div_divisor;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;
    logic                  div_valid_out;
    logic                  div_overflow;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready,
        output rsp_valid, rsp_id, rsp_quotient,
        output rsp_remainder, rsp_overflow, rsp_timeout,
        input  rsp_ready,
        output div_valid_in, div_dividend, div_divisor,
        input  div_quotient, div_remainder,
        input  div_valid_out, div_overflow
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_quotient,
        input  rsp_remainder, rsp_overflow, rsp_timeout,
        output rsp_ready,
        input  div_valid_in, div_dividend, div_divisor,
        output div_quotient, div_remainder,
        output div_valid_out, div_overflow
    );

endinterface

// File: rtl/div_scheduler_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module div_scheduler_rr_pick
    import div_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic [NUM_REQ-1:0]          grant,
    output logic [idx_w(NUM_REQ)-1:0]   idx,
    output logic                        any
);
    localparam int IW = idx_w(NUM_REQ);

    logic [IW:0] pos;

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        any   = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_REQ))
                pos = pos - (IW+1)'(NUM_REQ);
            if (req[pos[IW-1:0]]) begin
                grant              = '0;
                grant[pos[IW-1:0]] = 1'b1;
                idx                = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one iterative divider between NUM_REQ requesters with
// round-robin arbitration, a wait timeout and a tagged response.
module div_scheduler
    import div_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_SIZE,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    div_scheduler_if.slave bus
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = idx_w(TIMEOUT);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 2);

    sched_state_t state_q, state_d;

    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         gidx;
    logic                  any;
    logic [IW-1:0]         ptr_q;
    logic [IW-1:0]         id_q;
    logic [DATA_WIDTH-1:0] dvd_q, dvs_q;
    logic [DATA_WIDTH-1:0] quo_q, rem_q;
    logic                  ovf_q, tmo_q;
    logic [CW-1:0]         cnt_q;
    logic                  expire;
    logic [DATA_WIDTH-1:0] pick_dvd, pick_dvs;

    div_scheduler_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req  (bus.req_valid),
        .ptr  (ptr_q),
        .grant(grant),
        .idx  (gidx),
        .any  (any)
    );

    assign pick_dvd =
        bus.req_dividend[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign pick_dvs =
        bus.req_divisor[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

    // Counter starts at 0 in the first WAIT cycle, so the response
    // lands TIMEOUT cycles after the start strobe.
    assign expire = (cnt_q == CNT_END);

    assign bus.div_dividend  = dvd_q;
    assign bus.div_divisor   = dvs_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_quotient  = quo_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_overflow  = ovf_q;
    assign bus.rsp_timeout   = tmo_q;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready    = '0;
        bus.div_valid_in = 1'b0;
        bus.rsp_valid    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any && !reset) begin
                    bus.req_ready = grant;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                bus.div_valid_in = 1'b1;
                state_d          = WAIT;
            end
            WAIT: begin
                if (bus.div_valid_out || expire)
                    state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            id_q  <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any) begin
                        id_q  <= gidx;
                        dvd_q <= pick_dvd;
                        dvs_q <= pick_dvs;
                        ptr_q <= (gidx == LAST) ? '0 : gidx + 1'b1;
                    end
                end
                ISSUE: cnt_q <= '0;
                WAIT: begin
                    if (bus.div_valid_out) begin
                        quo_q <= bus.div_quotient;
                        rem_q <= bus.div_remainder;
                        ovf_q <= bus.div_overflow;
                        tmo_q <= 1'b0;
                    end else if (expire) begin
                        quo_q <= '0;
                        rem_q <= '0;
                        ovf_q <= 1'b0;
                        tmo_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: vector table plus multi-cycle sequences,
// a behavioural divider and a response scoreboard.
module tb_div_scheduler;
    import div_scheduler_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 16;

    typedef struct {
        int id;
        int a;
        int b;
        int q;
        int r;
        bit o;
        int lat;
    } vec_t;

    typedef struct {
        int         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       o;
        logic       t;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    int   grant_log[$];

    logic [W-1:0] cur_q [N];
    logic [W-1:0] cur_r [N];
    logic         cur_o [N];

    bit exp_tmo  = 1'b0;
    bit div_mute = 1'b0;
    int div_lat  = 3;

    logic busy;
    int   mcnt;

    div_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

    div_scheduler #(
        .NUM_REQ   (N),
        .DATA_WIDTH(W),
        .TIMEOUT   (TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Divider model: answers div_lat cycles after the start strobe,
    // computing from the operands it sees on that cycle.
    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            mcnt <= 0;
        end else if (bus.div_valid_in) begin
            busy <= 1'b1;
            mcnt <= div_lat - 1;
        end else if (busy) begin
            if (mcnt == 0)
                busy <= 1'b0;
            else
                mcnt <= mcnt - 1;
        end
    end

    assign bus.div_valid_out = busy && (mcnt == 0) && !div_mute;
    assign bus.div_overflow  = (bus.div_divisor == '0);
    assign bus.div_quotient  = bus.div_overflow ? '1 :
        W'($signed(bus.div_dividend) / $signed(bus.div_divisor));
    assign bus.div_remainder = bus.div_overflow ? bus.div_dividend :
        W'($signed(bus.div_dividend) % $signed(bus.div_divisor));

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.req_ready != '0) begin
                int   g;
                exp_t e;
                g = 0;
                chk("grant_onehot", 32'($onehot(bus.req_ready)), 1);
                chk("grant_valid",
                    32'(bus.req_ready & ~bus.req_valid), 0);
                for (int i = 0; i < N; i++)
                    if (bus.req_ready[i]) g = i;
                e.id = g;
                e.q  = exp_tmo ? '0 : cur_q[g];
                e.r  = exp_tmo ? '0 : cur_r[g];
                e.o  = exp_tmo ? 1'b0 : cur_o[g];
                e.t  = exp_tmo;
                sb.push_back(e);
                grant_log.push_back(g);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                exp_t e;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: id %0d, want none",
                             bus.rsp_id);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(bus.rsp_id), e.id);
                    chk("rsp_quotient", bus.rsp_quotient, e.q);
                    chk("rsp_remainder", bus.rsp_remainder, e.r);
                    chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(e.o));
                    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.t));
                end
            end
        end
    end

    task automatic set_req(input int id, input int a, input int b,
                           input int q, input int r, input bit o);
        cur_q[id] = q;
        cur_r[id] = r;
        cur_o[id] = o;
        bus.req_dividend[id*W +: W] = a;
        bus.req_divisor[id*W +: W]  = b;
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[id] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("grant_%0d", id), 32'(bus.req_ready[id]), 1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(n < 500), 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        grant_log.delete();
    endtask

    task automatic do_job(input vec_t v, input int lat_exp);
        int n;
        bit held;
        bit pulse;
        @(posedge clk);
        #1;
        div_lat = v.lat;
        set_req(v.id, v.a, v.b, v.q, v.r, v.o);
        @(negedge clk);
        chk("grant_now", 32'(bus.req_ready), 32'(1 << v.id));
        @(posedge clk);
        #1;
        bus.req_valid[v.id] = 1'b0;
        @(negedge clk);
        chk("issue", 32'(bus.div_valid_in), 1);
        n     = 0;
        held  = 1'b1;
        pulse = 1'b1;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
            held  &= (bus.div_dividend == v.a) &&
                     (bus.div_divisor == v.b);
            pulse &= !bus.div_valid_in;
        end
        chk("latency", n, lat_exp);
        chk("op_hold", 32'(held), 1);
        chk("issue_pulse", 32'(pulse), 1);
        @(negedge clk);
        chk("rsp_drop", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        vec_t vto;
        int   rr_exp [5];
        int   n;
        bit   stable;
        bit   quiet;
        logic [W-1:0] sq, sr;
        logic [1:0]   sid;
        logic         so, st;

        vt[0] = '{2,  100,  7,  14,  2, 1'b0, 3};
        vt[1] = '{1,   55,  0,  -1, 55, 1'b1, 2};
        vt[2] = '{0,    7, -2,  -3,  1, 1'b0, 1};
        vt[3] = '{3,   -9, -4,   2, -1, 1'b0, 5};
        vt[4] = '{2, -100,  7, -14, -2, 1'b0, 1};
        rr_exp = '{0, 1, 2, 3, 0};

        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_div_valid_in", 32'(bus.div_valid_in), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_div_dividend", bus.div_dividend, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            do_job(vt[i], vt[i].lat + 1);
        drain();

        // All requesters held valid from reset.
        pulse_reset();
        div_lat = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            set_req(i, (i + 1) * 10, 3,
                    ((i + 1) * 10) / 3, ((i + 1) * 10) % 3, 1'b0);
        n = 0;
        while (grant_log.size() < 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        drain();
        chk("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("rr_order_%0d", i), grant_log[i], rr_exp[i]);

        // Response backpressure with other requesters pending.
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        set_req(1, 50, 8, 6, 2, 1'b0);
        wait_grant(1);
        set_req(0, 81, 9, 9, 0, 1'b0);
        set_req(3, -81, 4, -20, -1, 1'b0);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        sid = bus.rsp_id;
        sq  = bus.rsp_quotient;
        sr  = bus.rsp_remainder;
        so  = bus.rsp_overflow;
        st  = bus.rsp_timeout;
        stable = 1'b1;
        quiet  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            stable &= bus.rsp_valid && (bus.rsp_id == sid) &&
                      (bus.rsp_quotient == sq) &&
                      (bus.rsp_remainder == sr) &&
                      (bus.rsp_overflow == so) &&
                      (bus.rsp_timeout == st);
            quiet &= (bus.req_ready == '0);
        end
        chk("bp_stable", 32'(stable), 1);
        chk("bp_no_accept", 32'(quiet), 1);
        chk("bp_id", 32'(sid), 1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_retired", 32'(bus.rsp_valid), 0);
        chk("bp_next_grant", 32'(bus.req_ready), 32'b1000);
        @(posedge clk);
        #1;
        bus.req_valid[3] = 1'b0;
        wait_grant(0);
        drain();

        // Divider that never answers.
        div_mute = 1'b1;
        exp_tmo  = 1'b1;
        vto = '{2, 9, 3, 0, 0, 1'b0, 4};
        do_job(vto, TMO);
        div_mute = 1'b0;
        exp_tmo  = 1'b0;
        drain();

        // Reset while waiting on the divider.
        @(posedge clk);
        #1;
        div_lat = 10;
        set_req(1, 1000, 10, 100, 0, 1'b0);
        wait_grant(1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_req_ready", 32'(bus.req_ready), 0);
        chk("mid_div_valid_in", 32'(bus.div_valid_in), 0);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rsp_timeout", 32'(bus.rsp_timeout), 0);
        chk("mid_rsp_overflow", 32'(bus.rsp_overflow), 0);
        chk("mid_rsp_id", 32'(bus.rsp_id), 0);
        chk("mid_div_dividend", bus.div_dividend, 0);
        chk("mid_div_divisor", bus.div_divisor, 0);
        chk("mid_rsp_quotient", bus.rsp_quotient, 0);
        chk("mid_rsp_remainder", bus.rsp_remainder, 0);
        reset = 1'b0;
        sb.delete();
        grant_log.delete();
        div_lat = 2;
        @(posedge clk);
        #1;
        set_req(1, 5, 2, 2, 1, 1'b0);
        set_req(3, -20, 6, -3, -2, 1'b0);
        wait_grant(1);
        wait_grant(3);
        drain();
        chk("post_rst_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            chk("post_rst_first", grant_log[0], 1);
            chk("post_rst_second", grant_log[1], 3);
        end

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
